vga_hvsync_generator: RTL and testbench

VGA timing generator for 640x480 at 60 Hz. It produces active-low horizontal and vertical sync, a display-enable flag, and the current pixel coordinates. It is clocked at the pixel clock (nominally 25.175 MHz; 25 MHz is acceptable). It sits at the front of the video pipeline: pixel/colour logic reads `hpos`/`vpos`/`display_on` and drives RGB, while `hsync`/`vsync` go straight to the output pins.

---
 rtl/vga_hvsync_generator.sv | 70 +++++++
 tb/tb_vga_hvsync_generator.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_hvsync_generator.sv
// VGA 640x480@60 timing generator: free-running pixel/line counters with
// registered active-low syncs and a combinational display-enable decode.
module vga_hvsync_generator #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] hpos,
   output logic [9:0] vpos
);

   localparam logic [9:0] H_LAST = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
   localparam logic [9:0] H_SS   = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_SE   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_SS   = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] V_SE   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [9:0] r_hpos;
   logic [9:0] r_vpos;
   logic       r_hsync;
   logic       r_vsync;
   logic [9:0] w_hpos_next;
   logic [9:0] w_vpos_next;
   logic       w_h_wrap;

   always_comb begin
      w_h_wrap    = (r_hpos == H_LAST);
      w_hpos_next = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
      w_vpos_next = r_vpos;
      if (w_h_wrap) begin
         w_vpos_next = (r_vpos == V_LAST) ? 10'd0 : r_vpos + 10'd1;
      end
   end

   // Syncs decode the next counter values so the registered pins line up
   // with the hpos/vpos they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hpos  <= 10'd0;
         r_vpos  <= 10'd0;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
      end else begin
         r_hpos  <= w_hpos_next;
         r_vpos  <= w_vpos_next;
         r_hsync <= !((w_hpos_next >= H_SS) && (w_hpos_next <= H_SE));
         r_vsync <= !((w_vpos_next >= V_SS) && (w_vpos_next <= V_SE));
      end
   end

   assign hpos       = r_hpos;
   assign vpos       = r_vpos;
   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign display_on = (r_hpos < H_VIS) && (r_vpos < V_VIS);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Directed bench: full-size instance for line timing, shrunken instance
// (15x13 totals) for frame-level behaviour and mid-frame reset.
module tb_vga_hvsync_generator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       m_hsync, m_vsync, m_de;
   logic [9:0] m_hpos, m_vpos;
   logic       s_hsync, s_vsync, s_de;
   logic [9:0] s_hpos, s_vpos;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vga_hvsync_generator u_main (
      .clk        (clk),
      .rst_n      (rst_n),
      .hsync      (m_hsync),
      .vsync      (m_vsync),
      .display_on (m_de),
      .hpos       (m_hpos),
      .vpos       (m_vpos)
   );

   // H: 8+2+3+2=15 (sync 10..12); V: 6+2+2+3=13 (sync 8..9); frame = 195 clocks
   vga_hvsync_generator #(
      .H_DISPLAY (8),
      .H_FRONT   (2),
      .H_SYNC    (3),
      .H_BACK    (2),
      .V_DISPLAY (6),
      .V_FRONT   (2),
      .V_SYNC    (2),
      .V_BACK    (3)
   ) u_small (
      .clk        (clk),
      .rst_n      (rst_n),
      .hsync      (s_hsync),
      .vsync      (s_vsync),
      .display_on (s_de),
      .hpos       (s_hpos),
      .vpos       (s_vpos)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_m_hpos"}, 32'(m_hpos), 0);
      check_eq({tag, "_m_vpos"}, 32'(m_vpos), 0);
      check_eq({tag, "_m_hsync"}, 32'(m_hsync), 1);
      check_eq({tag, "_m_vsync"}, 32'(m_vsync), 1);
      check_eq({tag, "_m_de"}, 32'(m_de), 1);
      check_eq({tag, "_s_hpos"}, 32'(s_hpos), 0);
      check_eq({tag, "_s_vpos"}, 32'(s_vpos), 0);
      check_eq({tag, "_s_hsync"}, 32'(s_hsync), 1);
      check_eq({tag, "_s_vsync"}, 32'(s_vsync), 1);
      check_eq({tag, "_s_de"}, 32'(s_de), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int eh, ev, hs_lows, hs_first, hs_last, de_fall, vs_lows, ticks, wait_n;
      bit prev_de, found;

      // Reset asserted before any clock edge must take effect at once
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_reset_state("rst_async");
      @(negedge clk) rst_n = 1'b1;

      // Two full lines on the full-size instance
      hs_lows = 0; hs_first = -1; hs_last = -1; de_fall = -1; prev_de = 1'b1;
      for (int k = 1; k <= 1600; k++) begin
         tick();
         eh = k % 800;
         ev = k / 800;
         if (k == 1) check_eq("hpos_after_release", 32'(m_hpos), 1);
         check_eq("line_hpos", 32'(m_hpos), 32'(eh));
         check_eq("line_vpos", 32'(m_vpos), 32'(ev));
         check_eq("line_hsync", 32'(m_hsync), (eh >= 656 && eh <= 751) ? 0 : 1);
         check_eq("line_vsync", 32'(m_vsync), 1);
         check_eq("line_de", 32'(m_de), (eh < 640) ? 1 : 0);
         if (k <= 800) begin
            if (!m_hsync) begin
               hs_lows++;
               if (hs_first < 0) hs_first = int'(m_hpos);
               hs_last = int'(m_hpos);
            end
            if (prev_de && !m_de && de_fall < 0) de_fall = int'(m_hpos);
            prev_de = m_de;
         end
         if (k == 799) check_eq("pre_wrap_hpos", 32'(m_hpos), 799);
         if (k == 800) check_eq("wrap_vpos", 32'(m_vpos), 1);
      end
      check_eq("hsync_low_count", 32'(hs_lows), 96);
      check_eq("hsync_first", 32'(hs_first), 656);
      check_eq("hsync_last", 32'(hs_last), 751);
      check_eq("de_fall_hpos", 32'(de_fall), 640);

      // Reset between edges while running; then one full small frame
      #3 rst_n = 1'b0;
      #1 check_reset_state("rst_run");
      @(negedge clk) rst_n = 1'b1;
      vs_lows = 0; ticks = 0;
      for (int k = 1; k <= 195; k++) begin
         tick();
         eh = k % 15;
         ev = (k / 15) % 13;
         check_eq("frm_hpos", 32'(s_hpos), 32'(eh));
         check_eq("frm_vpos", 32'(s_vpos), 32'(ev));
         check_eq("frm_hsync", 32'(s_hsync), (eh >= 10 && eh <= 12) ? 0 : 1);
         check_eq("frm_vsync", 32'(s_vsync), (ev >= 8 && ev <= 9) ? 0 : 1);
         check_eq("frm_de", 32'(s_de), (eh < 8 && ev < 6) ? 1 : 0);
         if (!s_vsync) vs_lows++;
         if (s_hpos == 10'd0 && s_vpos == 10'd0) ticks++;
         if (k == 194) begin
            check_eq("last_hpos", 32'(s_hpos), 14);
            check_eq("last_vpos", 32'(s_vpos), 12);
         end
      end
      check_eq("frame_wrap_hpos", 32'(s_hpos), 0);
      check_eq("frame_wrap_vpos", 32'(s_vpos), 0);
      check_eq("vsync_low_count", 32'(vs_lows), 30);
      check_eq("ticks_per_frame", 32'(ticks), 1);
      check_eq("main_hpos_195", 32'(m_hpos), 195);

      // Mid-frame reset at small (h=4, v=7)
      for (int k = 1; k <= 109; k++) tick();
      check_eq("mid_s_hpos", 32'(s_hpos), 4);
      check_eq("mid_s_vpos", 32'(s_vpos), 7);
      check_eq("mid_m_hpos", 32'(m_hpos), 304);
      #3 rst_n = 1'b0;
      #1 check_reset_state("rst_mid");
      @(negedge clk) rst_n = 1'b1;
      tick();
      check_eq("mid_leave0_hpos", 32'(s_hpos), 1);
      check_eq("mid_leave0_vpos", 32'(s_vpos), 0);
      wait_n = 1; found = 1'b0;
      while (!found && wait_n < 400) begin
         tick();
         wait_n++;
         if (s_hpos == 10'd0 && s_vpos == 10'd0) found = 1'b1;
      end
      check_eq("tick_found", 32'(found), 1);
      check_eq("tick_period", 32'(wait_n), 195);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
